// File: rtl/sobel_out_packer.sv
// sobel_out_packer: packs per-beat Sobel magnitudes into 64-bit SRAM2 words and sequences frame addresses.
// Optional direction packing into SRAM3 is enabled by defining SOBEL_DIR_OUT_EN.
module sobel_out_packer #(
    parameter int BASEADDR2   = 0,
    parameter int BASEADDR3   = 0,
    parameter int FRAME_WORDS = 32768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startEn,
    input  logic        pixValid,
    input  logic [31:0] magIn,
    input  logic [7:0]  dirIn,
    input  logic        frameEnd,
    output logic        we2,
    output logic [19:0] write_addr2,
    output logic [63:0] data2,
    output logic        we3,
    output logic [19:0] write_addr3,
    output logic [63:0] data3,
    output logic        busy,
    output logic        frameDone
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [19:0] BASE2 = 20'(BASEADDR2);
    localparam logic [19:0] LAST  = 20'(FRAME_WORDS - 1);

    state_t      r_state, w_next;
    logic        r_phase;
    logic [31:0] r_half;
    logic [19:0] r_cnt;
    logic        r_we2;
    logic [19:0] r_addr2;
    logic [63:0] r_data2;
    logic        r_busy;
    logic        r_done;
    logic        w_beat;
    logic        w_last;

    assign w_beat = r_state == RUN && pixValid;
    assign w_last = w_beat && r_phase && r_cnt == LAST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = startEn ? RUN : IDLE;
            RUN:     w_next = w_last ? DONE : frameEnd ? FLUSH : RUN;
            FLUSH:   w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Address advances on the edge after a write so address and data stay aligned while we2 is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= 1'b0;
            r_half  <= '0;
            r_cnt   <= '0;
            r_we2   <= 1'b0;
            r_addr2 <= BASE2;
            r_data2 <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_we2  <= 1'b0;
            r_done <= 1'b0;
            if (r_we2) r_addr2 <= r_addr2 + 20'd1;
            if (r_state == IDLE && startEn) begin
                r_busy  <= 1'b1;
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end
            if (w_beat) begin
                r_phase <= ~r_phase;
                if (r_phase) begin
                    r_data2 <= {r_half, magIn};
                    r_we2   <= 1'b1;
                    r_cnt   <= r_cnt + 20'd1;
                end else begin
                    r_half <= magIn;
                end
            end
            if (r_state == FLUSH && r_phase) begin
                r_data2 <= {r_half, 32'h0};
                r_we2   <= 1'b1;
                r_phase <= 1'b0;
            end
            if (r_state == DONE) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_addr2 <= BASE2;
            end
        end
    end

    assign we2         = r_we2;
    assign write_addr2 = r_addr2;
    assign data2       = r_data2;
    assign busy        = r_busy;
    assign frameDone   = r_done;

`ifdef SOBEL_DIR_OUT_EN
    localparam logic [19:0] BASE3 = 20'(BASEADDR3);

    logic [63:0] r_dir;
    logic [2:0]  r_dcnt;
    logic        r_we3;
    logic [19:0] r_addr3;
    logic [63:0] r_data3;
    logic [63:0] w_dir;

    // Beat k of a word lands in byte 7-k, so the first direction sits in [63:56].
    assign w_dir = r_dir | ({56'd0, dirIn} << {3'd7 - r_dcnt, 3'b000});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dir   <= '0;
            r_dcnt  <= '0;
            r_we3   <= 1'b0;
            r_addr3 <= BASE3;
            r_data3 <= '0;
        end else begin
            r_we3 <= 1'b0;
            if (r_we3) r_addr3 <= r_addr3 + 20'd1;
            if (r_state == IDLE && startEn) begin
                r_dir  <= '0;
                r_dcnt <= '0;
            end else if (w_beat) begin
                r_dcnt <= r_dcnt + 3'd1;
                if (r_dcnt == 3'd7) begin
                    r_data3 <= w_dir;
                    r_we3   <= 1'b1;
                    r_dir   <= '0;
                end else begin
                    r_dir <= w_dir;
                end
            end else if (r_state == FLUSH && r_dcnt != 3'd0) begin
                r_data3 <= r_dir;
                r_we3   <= 1'b1;
                r_dir   <= '0;
                r_dcnt  <= '0;
            end else if (r_state == DONE) begin
                r_addr3 <= BASE3;
            end
        end
    end

    assign we3         = r_we3;
    assign write_addr3 = r_addr3;
    assign data3       = r_data3;
`else
    logic w_unused;

    assign w_unused    = ^{dirIn, BASEADDR3};
    assign we3         = 1'b0;
    assign write_addr3 = '0;
    assign data3       = '0;
`endif
endmodule

// File: tb/tb_sobel_out_packer.sv
// tb_sobel_out_packer: directed stimulus with a scoreboard of expected SRAM writes and frameDone pulses.
module tb_sobel_out_packer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        startEn = 1'b0;
    logic        pixValid = 1'b0;
    logic [31:0] magIn = '0;
    logic [7:0]  dirIn = '0;
    logic        frameEnd = 1'b0;
    logic        we2, we3, busy, frameDone;
    logic [19:0] write_addr2, write_addr3;
    logic [63:0] data2, data3;

    localparam logic [19:0] B2 = 20'hFFFFF;
    localparam logic [19:0] B3 = 20'h00010;

    sobel_out_packer #(.BASEADDR2(B2), .BASEADDR3(B3), .FRAME_WORDS(4)) dut (
        .clk(clk), .reset(reset), .startEn(startEn), .pixValid(pixValid), .magIn(magIn),
        .dirIn(dirIn), .frameEnd(frameEnd), .we2(we2), .write_addr2(write_addr2), .data2(data2),
        .we3(we3), .write_addr3(write_addr3), .data3(data3), .busy(busy), .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] a;
        logic [63:0] d;
        int          c;
    } wr_t;

    wr_t q2[$];
    wr_t q3[$];
    int  qd[$];
    wr_t m_e;
    int  cyc = 0;
    int  errs = 0;
    int  checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic s, input logic pv, input logic [31:0] m, input logic [7:0] d, input logic fe);
        @(negedge clk);
        startEn = s; pixValid = pv; magIn = m; dirIn = d; frameEnd = fe;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, '0, '0, 0);
    endtask

    task automatic exp2(input logic [19:0] a, input logic [63:0] d, input int off);
        q2.push_back('{a, d, cyc + off});
    endtask

    task automatic exp3(input logic [19:0] a, input logic [63:0] d, input int off);
`ifdef SOBEL_DIR_OUT_EN
        q3.push_back('{a, d, cyc + off});
`endif
    endtask

    task automatic expd(input int off);
        qd.push_back(cyc + off);
    endtask

    always @(posedge clk) begin
        #1;
        while (q2.size() > 0 && q2[0].c < cyc) begin
            checks++; errs++;
            $display("FAIL w2_missed: no write seen, expected addr %h data %h at cycle %0d", q2[0].a, q2[0].d, q2[0].c);
            void'(q2.pop_front());
        end
        if (we2) begin
            if (q2.size() == 0) begin
                checks++; errs++;
                $display("FAIL w2_unexpected: got write addr %h data %h, expected no write (cycle %0d)", write_addr2, data2, cyc);
            end else begin
                m_e = q2.pop_front();
                chk("w2_addr", write_addr2, m_e.a);
                chk("w2_data", data2, m_e.d);
                chk("w2_cycle", cyc, m_e.c);
            end
        end
        while (qd.size() > 0 && qd[0] < cyc) begin
            checks++; errs++;
            $display("FAIL done_missed: got no frameDone, expected at cycle %0d", qd[0]);
            void'(qd.pop_front());
        end
        if (frameDone) begin
            if (qd.size() == 0) begin
                checks++; errs++;
                $display("FAIL done_unexpected: got frameDone at cycle %0d, expected none", cyc);
            end else begin
                chk("done_cycle", cyc, qd.pop_front());
            end
        end
`ifdef SOBEL_DIR_OUT_EN
        while (q3.size() > 0 && q3[0].c < cyc) begin
            checks++; errs++;
            $display("FAIL w3_missed: no write seen, expected addr %h data %h at cycle %0d", q3[0].a, q3[0].d, q3[0].c);
            void'(q3.pop_front());
        end
        if (we3) begin
            if (q3.size() == 0) begin
                checks++; errs++;
                $display("FAIL w3_unexpected: got write addr %h data %h, expected no write (cycle %0d)", write_addr3, data3, cyc);
            end else begin
                m_e = q3.pop_front();
                chk("w3_addr", write_addr3, m_e.a);
                chk("w3_data", data3, m_e.d);
                chk("w3_cycle", cyc, m_e.c);
            end
        end
`else
        chk("we3_off", we3, 0);
        chk("addr3_off", write_addr3, 0);
        chk("data3_off", data3, 0);
`endif
    end

    initial begin
        logic [31:0] m;
        logic [31:0] pm;
        @(negedge clk);
        chk("rst_we2", we2, 0);
        chk("rst_addr2", write_addr2, B2);
        chk("rst_data2", data2, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frameDone, 0);
        reset = 1'b1;
        idle(2);

        // two beats -> one word, then frameEnd with nothing pending
        drive(1, 0, '0, '0, 0);
        drive(0, 1, 32'h01020304, 8'h01, 0);
        chk("busy_run", busy, 1);
        drive(0, 1, 32'h05060708, 8'h02, 0);
        exp2(B2, 64'h0102030405060708, 1);
        drive(0, 0, '0, '0, 1);
        exp3(B3, 64'h0102000000000000, 2);
        expd(3);
        idle(3);
        chk("busy_idle1", busy, 0);
        idle(2);

        // count exit: 10 beats, only 8 used; addresses wrap past 0xFFFFF
        drive(1, 0, '0, '0, 0);
        pm = '0;
        for (int b = 1; b <= 10; b++) begin
            m = 32'(b) * 32'h01010101;
            drive(0, 1, m, 8'(b), 0);
            if (b % 2 == 0 && b <= 8) exp2(B2 + 20'(b / 2 - 1), {pm, m}, 1);
            if (b == 8) begin
                exp3(B3, 64'h0102030405060708, 1);
                expd(2);
            end
            pm = m;
        end
        idle(1);
        chk("busy_idle2", busy, 0);
        idle(3);

        // frameEnd on the third beat -> flush of {beat3, 0}; startEn while busy ignored
        drive(1, 0, '0, '0, 0);
        drive(0, 1, 32'hA1A2A3A4, 8'h0A, 0);
        drive(1, 1, 32'hB1B2B3B4, 8'h0B, 0);
        exp2(B2, 64'hA1A2A3A4B1B2B3B4, 1);
        drive(0, 1, 32'hC1C2C3C4, 8'h0C, 1);
        exp2(20'h00000, 64'hC1C2C3C400000000, 2);
        exp3(B3, 64'h0A0B0C0000000000, 2);
        expd(3);
        idle(1);
        chk("busy_flush", busy, 1);
        idle(4);
        chk("busy_idle3", busy, 0);

        // reset mid-frame with a half word pending
        drive(1, 0, '0, '0, 0);
        drive(0, 1, 32'h11223344, 8'h01, 0);
        drive(0, 1, 32'h55667788, 8'h02, 0);
        exp2(B2, 64'h1122334455667788, 1);
        drive(0, 1, 32'h99AABBCC, 8'h03, 0);
        @(negedge clk);
        reset = 1'b0;
        pixValid = 1'b0;
        #1;
        chk("mid_rst_we2", we2, 0);
        chk("mid_rst_addr2", write_addr2, B2);
        chk("mid_rst_data2", data2, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", frameDone, 0);
`ifdef SOBEL_DIR_OUT_EN
        chk("mid_rst_addr3", write_addr3, B3);
        chk("mid_rst_data3", data3, 0);
`endif
        idle(2);
        reset = 1'b1;
        idle(1);
        drive(1, 0, '0, '0, 0);
        drive(0, 1, 32'hDEADBEEF, 8'h05, 0);
        drive(0, 1, 32'h0BADF00D, 8'h06, 0);
        exp2(B2, 64'hDEADBEEF0BADF00D, 1);
        drive(0, 0, '0, '0, 1);
        exp3(B3, 64'h0506000000000000, 2);
        expd(3);
        idle(6);

        chk("q2_drained", q2.size(), 0);
        chk("q3_drained", q3.size(), 0);
        chk("qd_drained", qd.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/sobel_out_packer.md
Name: sobel_out_packer

Overview:
- Downstream stage of the Sobel filter.
- Accepts the four normalised 8-bit magnitudes produced per beat (one per Sobel lane) plus lane-1 gradient direction.
- Packs magnitudes into 64-bit words and writes them to output SRAM2 through port 2.
- Optionally packs directions into SRAM3 through port 3.
- Owns the frame write-address sequencing and reports frame completion to the controller.

Parameters:
- BASEADDR2, 0: first SRAM2 word address of a frame.
- BASEADDR3, 0: first SRAM3 word address of a frame (direction path).
- FRAME_WORDS, 32768: magnitude words per frame (512x512 pixels / 8 bytes per word).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- startEn  in  1  frame start strobe; sampled in IDLE only.
- pixValid  in  1  magIn/dirIn hold a valid beat this cycle.
- magIn  in  32  lane1..lane4 magnitudes; lane1 in [31:24], lane4 in [7:0].
- dirIn  in  8  lane-1 direction code for this beat.
- frameEnd  in  1  upstream end-of-data; forces flush of a partial word.
- we2  out  1  SRAM2 write enable, single-cycle pulse.
- write_addr2  out  20  SRAM2 word address.
- data2  out  64  SRAM2 write data.
- we3  out  1  SRAM3 write enable (direction path).
- write_addr3  out  20  SRAM3 word address.
- data3  out  64  SRAM3 write data.
- busy  out  1  high from leaving IDLE until return to IDLE.
- frameDone  out  1  single-cycle pulse after the last frame write.

Behaviour:
- reset low, asynchronous: all outputs 0, state IDLE, counters and half-word register cleared, write_addr2 = BASEADDR2, write_addr3 = BASEADDR3. Applies mid-frame too; any partial word is discarded.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: pixValid and frameEnd ignored. startEn=1 -> RUN next edge; busy=1 and word counter = 0 on that edge.
- RUN, beat capture:
  - Each edge with pixValid=1 captures magIn.
  - Even beat: stored in the half register.
  - Odd beat: on the same edge, data2 <= {previous half, magIn}; we2 <= 1; word counter increments.
  - Result: first beat occupies [63:32], second [31:0]; we2 is visible the cycle after the completing beat (latency 1).
- Address: first write uses BASEADDR2. write_addr2 is updated to the next address on the edge after each write, so address and data are stable together while we2=1. 20-bit arithmetic, wraps modulo 2^20.
- we2 and we3 are high for exactly one cycle per write. No backpressure: SRAM writes always complete.
- RUN exit on count: the write that makes word counter == FRAME_WORDS moves to DONE. Beats arriving in DONE or IDLE are dropped.
- RUN exit on frameEnd:
  - frameEnd=1 in RUN -> FLUSH. A beat on the same edge is captured first.
  - FLUSH, half word pending: one write of {half, 32'h0}.
  - FLUSH, nothing pending: no write.
  - FLUSH then -> DONE.
- DONE: frameDone=1 for one cycle, busy=0, then IDLE. Addresses reload to BASEADDR2/3 on entry to IDLE.
- startEn while busy is ignored.
- pixValid may be asserted every cycle, so sustained throughput is 1 beat/clk.

Optional Feature:
- Macro: SOBEL_DIR_OUT_EN.
- Defined:
  - Each captured beat shifts dirIn into a 64-bit direction register; the first beat lands in [63:56].
  - Every 8th beat writes data3 with we3=1, following the same timing and address rules as port 2, starting at BASEADDR3.
  - FLUSH also writes a partial direction word, left-aligned and zero-padded, in the same cycle as the port-2 flush write. If only the direction word is partial, only we3 pulses.
- Undefined: dirIn ignored; we3, data3, write_addr3 held at 0; no direction logic synthesised.

Test Plan:
- Reset low mid-RUN after 3 beats -> all outputs 0 immediately, no further we2, busy=0; next startEn restarts at BASEADDR2.
- startEn, then beats 0x01020304 and 0x05060708 on consecutive cycles -> one we2 pulse, data2=0x0102030405060708, write_addr2=BASEADDR2, we2 high the cycle after the second beat.
- FRAME_WORDS=4, 10 continuous beats -> exactly 4 we2 pulses at addresses 0..3, frameDone one cycle later, last 2 beats dropped, busy falls.
- 3 beats then frameEnd (with the 3rd beat on the same edge as frameEnd) -> writes 2 words; the second word is {beat3, 32'h0}; frameDone follows.
- BASEADDR2=20'hFFFFF, 2 words -> addresses 0xFFFFF then 0x00000.
- SOBEL_DIR_OUT_EN, dirIn = 1..8 over 8 beats -> single we3, data3=0x0102030405060708, write_addr3=BASEADDR3; without the macro, we3 stays 0.
